data_mem_responder: RTL and testbench

- Responder end of the memory-stage load/store interface: accepts one request at a time from the pipeline's Memory stage (initiator) and returns read data or a store acknowledgement after a programmable wait-state latency.
- Owns the word-organised data RAM.
- Performs byte-lane store merging and load sign/zero extension per funct3.
- Flags misaligned, out-of-range and illegal-funct3 accesses.
- Sits behind the Memory stage and replaces the zero-latency combinational data memory.

---
 rtl/data_mem_responder_pkg.sv | 37 +++
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder_load_store_align.sv | 42 ++++
 rtl/data_mem_responder.sv | 116 +++++++++++
 tb/tb_data_mem_responder.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the memory-stage load/store responder: access encodings,
// responder FSM states and the latched request bundle.
package data_mem_responder_pkg;

    typedef enum logic [2:0] {
        LT_LB  = 3'b000,
        LT_LH  = 3'b001,
        LT_LW  = 3'b010,
        LT_LBU = 3'b100,
        LT_LHU = 3'b101
    } load_type_e;

    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } store_type_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } mem_rsp_state_e;

    typedef struct packed {
        logic        we;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

    function automatic logic funct3_illegal(input logic we, input logic [2:0] f3);
        if (we) return !(f3 inside {3'b000, 3'b001, 3'b010});
        return f3 inside {3'b011, 3'b110, 3'b111};
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response handshake between the Memory stage (master) and the
// data memory responder (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder_load_store_align.sv
// Byte-lane steering: store byte enables and lane replication, load lane
// select with sign/zero extension, and natural-alignment check.
module load_store_align
    import data_mem_responder_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [31:0] shifted;

    always_comb begin
        be        = 4'b0000;
        wdata_rep = wdata;
        rdata_ext = 32'h0;
        shifted   = rword >> {addr_lo, 3'b000};
        // funct3[1:0] is the access size for both loads and stores
        misalign  = (funct3[1:0] == 2'b10 && addr_lo != 2'b00) ||
                    (funct3[1:0] == 2'b01 && addr_lo[0]);

        case (funct3)
            ST_SB:   begin be = 4'b0001 << addr_lo; wdata_rep = {4{wdata[7:0]}};  end
            ST_SH:   begin be = 4'b0011 << addr_lo; wdata_rep = {2{wdata[15:0]}}; end
            ST_SW:   be = 4'b1111;
            default: be = 4'b0000;
        endcase

        case (funct3)
            LT_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
            LT_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
            LT_LW:   rdata_ext = rword;
            LT_LBU:  rdata_ext = {24'h0, shifted[7:0]};
            LT_LHU:  rdata_ext = {16'h0, shifted[15:0]};
            default: rdata_ext = 32'h0;
        endcase
    end
endmodule

// File: rtl/data_mem_responder.sv
// Data RAM responder: one request at a time, WAIT_CYCLES wait states, then a
// registered response held until the initiator takes it.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
)(
    input logic                 clk,
    input logic                 rst_n,
    data_mem_responder_if.slave bus
);
    localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mem_rsp_state_e state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    mem_req_t       req_q, req_d, cur;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;

    logic [31:0]    mem [DEPTH_WORDS];

    logic           accept, commit, in_range, err_now, misalign;
    logic [31:0]    offset, rword, wrep, rext;
    logic [IDX_W-1:0] idx;
    logic [3:0]     be;

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign accept        = bus.req_valid && (state_q == S_IDLE);

    // With zero wait states the commit edge is the accept edge, so the
    // access must be evaluated on the live request instead of the latch.
    always_comb begin
        cur = req_q;
        if (state_q == S_IDLE)
            cur = '{we: bus.req_we, funct3: bus.req_funct3,
                    addr: bus.req_addr, wdata: bus.req_wdata};
    end

    assign offset   = cur.addr - BASE_ADDR;
    assign idx      = IDX_W'(offset >> 2);
    assign in_range = ({1'b0, cur.addr} >= {1'b0, BASE_ADDR}) && ({1'b0, cur.addr} < END_ADDR);
    assign rword    = in_range ? mem[idx] : 32'h0;
    assign err_now  = misalign || !in_range || funct3_illegal(cur.we, cur.funct3);
    assign commit   = rst_n && ((accept && WAIT_CYCLES == 0) ||
                                (state_q == S_WAIT && cnt_q == 4'd0));

    load_store_align u_align (
        .funct3    (cur.funct3),
        .addr_lo   (cur.addr[1:0]),
        .wdata     (cur.wdata),
        .rword     (rword),
        .be        (be),
        .wdata_rep (wrep),
        .rdata_ext (rext),
        .misalign  (misalign)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (accept) begin
                req_d = cur;
                if (WAIT_CYCLES == 0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d   = CNT_INIT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: if (cnt_q == 4'd0) state_d = S_RESP;
                    else               cnt_d   = cnt_q - 4'd1;
            S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            err_d   = err_now;
            rdata_d = (err_now || cur.we) ? 32'h0 : rext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM has no reset; commit is already gated by rst_n
    always_ff @(posedge clk) begin
        if (commit && cur.we && !err_now) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wrep[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: every scenario runs against a WAIT_CYCLES=2 and a
// WAIT_CYCLES=0 responder, selected by sel.
module tb_data_mem_responder;
    localparam logic [2:0] F_LB = 3'b000, F_LH = 3'b001, F_LW = 3'b010, F_LBU = 3'b100, F_LHU = 3'b101;
    localparam logic [2:0] F_SB = 3'b000, F_SH = 3'b001, F_SW = 3'b010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    int          w;
    int          tests = 0;
    int          fails = 0;

    logic        req_valid, req_we, rsp_ready;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        o_req_ready, o_rsp_valid, o_rsp_err;
    logic [31:0] o_rsp_rdata;

    always #5 clk = ~clk;

    data_mem_responder_if bus2 ();
    data_mem_responder_if bus0 ();

    assign bus2.req_valid  = req_valid && !sel;
    assign bus2.rsp_ready  = rsp_ready && !sel;
    assign bus2.req_we     = req_we;
    assign bus2.req_funct3 = req_funct3;
    assign bus2.req_addr   = req_addr;
    assign bus2.req_wdata  = req_wdata;
    assign bus0.req_valid  = req_valid && sel;
    assign bus0.rsp_ready  = rsp_ready && sel;
    assign bus0.req_we     = req_we;
    assign bus0.req_funct3 = req_funct3;
    assign bus0.req_addr   = req_addr;
    assign bus0.req_wdata  = req_wdata;

    assign o_req_ready = sel ? bus0.req_ready : bus2.req_ready;
    assign o_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
    assign o_rsp_rdata = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
    assign o_rsp_err   = sel ? bus0.rsp_err   : bus2.rsp_err;

    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) dut_w2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));
    data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) dut_w0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Drives one request and consumes its response; lat counts edges from
    // accept until rsp_valid is visible (expected == WAIT_CYCLES).
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd, output logic er,
                          output int lat);
        int n;
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (o_rsp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        if (lat >= 40) begin
            tests++; fails++;
            $display("FAIL timeout w=%0d addr=%h: no rsp_valid after %0d cycles", w, a, lat);
        end
        rd = o_rsp_rdata; er = o_rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready w=%0d got %b want 1", w, o_req_ready); end
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_valid w=%0d got %b want 0", w, o_rsp_valid); end
        tests++; if (o_rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata w=%0d got %h want 0", w, o_rsp_rdata); end
        tests++; if (o_rsp_err !== 1'b0) begin fails++; $display("FAIL rst_err w=%0d got %b want 0", w, o_rsp_err); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++; if (o_req_ready !== 1'b1) begin fails++; $display("FAIL post_rst_ready w=%0d got %b want 1", w, o_req_ready); end
    endtask

    task automatic test_store_word();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, F_SW, 32'h10, 32'hDEADBEEF, rd, er, lat);
        tests++; if (lat !== w) begin fails++; $display("FAIL sw_latency w=%0d got %0d want %0d", w, lat, w); end
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL sw_err w=%0d got %b want 0", w, er); end
        tests++; if (rd !== 32'h0) begin fails++; $display("FAIL sw_rdata w=%0d got %h want 0", w, rd); end
        do_req(1'b0, F_LW, 32'h10, 32'h0, rd, er, lat);
        tests++; if (lat !== w) begin fails++; $display("FAIL lw_latency w=%0d got %0d want %0d", w, lat, w); end
        tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_word w=%0d got %h want deadbeef", w, rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, F_SW, 32'h10, 32'h0, rd, er, lat);
        do_req(1'b1, F_SB, 32'h11, 32'h1234567F, rd, er, lat);
        do_req(1'b1, F_SB, 32'h12, 32'h00000080, rd, er, lat);
        do_req(1'b0, F_LW, 32'h10, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h00807F00) begin fails++; $display("FAIL sb_merge w=%0d got %h want 00807f00", w, rd); end
        do_req(1'b0, F_LB, 32'h12, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_sext w=%0d got %h want ffffff80", w, rd); end
        do_req(1'b0, F_LBU, 32'h12, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h00000080) begin fails++; $display("FAIL lbu_zext w=%0d got %h want 00000080", w, rd); end
        do_req(1'b0, F_LB, 32'h11, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h0000007F) begin fails++; $display("FAIL lb_pos w=%0d got %h want 0000007f", w, rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b1, F_SW, 32'h20, 32'h0, rd, er, lat);
        do_req(1'b1, F_SH, 32'h22, 32'h5555BEEF, rd, er, lat);
        do_req(1'b0, F_LH, 32'h22, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hFFFFBEEF) begin fails++; $display("FAIL lh_sext w=%0d got %h want ffffbeef", w, rd); end
        do_req(1'b0, F_LHU, 32'h22, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h0000BEEF) begin fails++; $display("FAIL lhu_zext w=%0d got %h want 0000beef", w, rd); end
        do_req(1'b0, F_LW, 32'h20, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hBEEF0000) begin fails++; $display("FAIL sh_word w=%0d got %h want beef0000", w, rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        do_req(1'b0, F_LW, 32'h13, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lw_misalign w=%0d got err=%b rd=%h want err=1 rd=0", w, er, rd); end
        do_req(1'b1, F_SW, 32'h24, 32'h11223344, rd, er, lat);
        do_req(1'b1, F_SH, 32'h25, 32'hAAAA9999, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL sh_misalign w=%0d got err=%b want 1", w, er); end
        do_req(1'b1, 3'b011, 32'h24, 32'hAAAA9999, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL st_funct3 w=%0d got err=%b want 1", w, er); end
        do_req(1'b0, F_LW, 32'h24, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'h11223344) begin fails++; $display("FAIL err_nowrite w=%0d got %h want 11223344", w, rd); end
        do_req(1'b0, F_LW, 32'h1000, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL lw_range w=%0d got err=%b rd=%h want err=1 rd=0", w, er, rd); end
        do_req(1'b0, F_LW, 32'hFFC, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b0) begin fails++; $display("FAIL lw_last w=%0d got err=%b want 0", w, er); end
        do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL ld_funct3 w=%0d got err=%b rd=%h want err=1 rd=0", w, er, rd); end
        do_req(1'b0, F_LH, 32'h11, 32'h0, rd, er, lat);
        tests++; if (er !== 1'b1) begin fails++; $display("FAIL lh_misalign w=%0d got err=%b want 1", w, er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; int n;
        do_req(1'b1, F_SW, 32'h40, 32'hCAFEF00D, rd, er, lat);
        req_we = 1'b0; req_funct3 = F_LW; req_addr = 32'h40; req_wdata = 32'h0; req_valid = 1'b1;
        n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (o_rsp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        tests++; if (n >= 40) begin fails++; $display("FAIL bp_timeout w=%0d got no rsp_valid want rsp_valid", w); end
        req_we = 1'b1; req_funct3 = F_SW; req_addr = 32'h40; req_wdata = 32'h0; req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if (o_rsp_valid !== 1'b1 || o_rsp_rdata !== 32'hCAFEF00D || o_rsp_err !== 1'b0 || o_req_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold w=%0d cyc=%0d got v=%b rd=%h e=%b rdy=%b want v=1 rd=cafef00d e=0 rdy=0",
                         w, i, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_req_ready);
            end
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests++; if (o_rsp_valid !== 1'b0) begin fails++; $display("FAIL bp_release w=%0d got %b want 0", w, o_rsp_valid); end
        do_req(1'b0, F_LW, 32'h40, 32'h0, rd, er, lat);
        tests++; if (rd !== 32'hCAFEF00D) begin fails++; $display("FAIL bp_ignored_req w=%0d got %h want cafef00d", w, rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; int n;
        logic [31:0] want;
        do_req(1'b1, F_SW, 32'h30, 32'h0, rd, er, lat);
        req_we = 1'b1; req_funct3 = F_SW; req_addr = 32'h30; req_wdata = 32'h12345678; req_valid = 1'b1;
        n = 0;
        while (o_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        tests++;
        if (o_req_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_rsp_rdata !== 32'h0 || o_rsp_err !== 1'b0) begin
            fails++;
            $display("FAIL mid_rst_out w=%0d got rdy=%b v=%b rd=%h e=%b want rdy=1 v=0 rd=0 e=0",
                     w, o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        // zero-wait store committed on its accept edge, before the reset
        want = (w == 0) ? 32'h12345678 : 32'h0;
        do_req(1'b0, F_LW, 32'h30, 32'h0, rd, er, lat);
        tests++; if (rd !== want) begin fails++; $display("FAIL mid_rst_mem w=%0d got %h want %h", w, rd, want); end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; sel = 1'b0; w = 2;
        req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            w   = (s == 1) ? 0 : 2;
            test_reset();
            test_store_word();
            test_byte_lanes();
            test_half();
            test_errors();
            test_backpressure();
            test_reset_mid();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
